// File: rtl/result_drain_ctrl_if.sv
// Drain-controller bus bundle: start/status, results SRAM read port and host output stream.
// master = drain controller side, slave = environment (SRAM + host sink + sequencer).
interface result_drain_ctrl_if #(
    parameter int unsigned ADDRESSSIZE    = 10,
    parameter int unsigned PARTIAL_SUM_BW = 20,
    parameter int unsigned MATRIX_SIZE    = 8,
    parameter int unsigned OUT_BW         = 32
);
    localparam int unsigned ROW_W = PARTIAL_SUM_BW * MATRIX_SIZE;

    logic                   start;
    logic [ADDRESSSIZE-1:0] base_addr;
    logic [ADDRESSSIZE-1:0] num_rows;
    logic                   busy;
    logic                   done;
    logic                   sram_rd_en;
    logic [ADDRESSSIZE-1:0] sram_addr;
    logic [ROW_W-1:0]       sram_rdata;
    logic                   m_valid;
    logic                   m_ready;
    logic [OUT_BW-1:0]      m_data;
    logic                   m_last;

    modport master (
        input  start, base_addr, num_rows, sram_rdata, m_ready,
        output busy, done, sram_rd_en, sram_addr, m_valid, m_data, m_last
    );

    modport slave (
        output start, base_addr, num_rows, sram_rdata, m_ready,
        input  busy, done, sram_rd_en, sram_addr, m_valid, m_data, m_last
    );
endinterface

// File: rtl/result_drain_ctrl.sv
// Reads packed result rows from the results SRAM and serialises them lane by lane,
// sign-extended, onto a valid/ready stream. All outputs are registered from the next state.
module result_drain_ctrl #(
    parameter int unsigned ADDRESSSIZE    = 10,
    parameter int unsigned PARTIAL_SUM_BW = 20,
    parameter int unsigned MATRIX_SIZE    = 8,
    parameter int unsigned OUT_BW         = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    result_drain_ctrl_if.master  bus
);
    localparam int unsigned ROW_W  = PARTIAL_SUM_BW * MATRIX_SIZE;
    localparam int unsigned LANE_W = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
    localparam int unsigned CMP_W  = ADDRESSSIZE + 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(MATRIX_SIZE - 1);

    typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, DONE} state_e;

    state_e                  state_q, state_d;
    logic [ADDRESSSIZE-1:0]  base_q, base_d;
    logic [ADDRESSSIZE-1:0]  num_q, num_d;
    logic [ADDRESSSIZE-1:0]  row_q, row_d;
    logic [LANE_W-1:0]       lane_q, lane_d;
    logic [ROW_W-1:0]        shift_q, shift_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    sram_rd_en_q, sram_rd_en_d;
    logic [ADDRESSSIZE-1:0]  sram_addr_q, sram_addr_d;
    logic                    m_valid_q, m_valid_d;
    logic [OUT_BW-1:0]       m_data_q, m_data_d;
    logic                    m_last_q, m_last_d;
    logic [PARTIAL_SUM_BW-1:0] lane_val;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            base_q       <= '0;
            num_q        <= '0;
            row_q        <= '0;
            lane_q       <= '0;
            shift_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            sram_rd_en_q <= 1'b0;
            sram_addr_q  <= '0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_last_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            num_q        <= num_d;
            row_q        <= row_d;
            lane_q       <= lane_d;
            shift_q      <= shift_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            sram_rd_en_q <= sram_rd_en_d;
            sram_addr_q  <= sram_addr_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_last_q     <= m_last_d;
        end
    end

    // Next state, counters and the row shift register.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        num_d   = num_q;
        row_d   = row_q;
        lane_d  = lane_q;
        shift_d = shift_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    base_d  = bus.base_addr;
                    num_d   = bus.num_rows;
                    row_d   = '0;
                    state_d = (bus.num_rows == '0) ? DONE : READ;
                end
            end
            READ: state_d = WAIT;
            WAIT: begin
                shift_d = bus.sram_rdata;
                lane_d  = '0;
                state_d = SEND;
            end
            SEND: begin
                if (bus.m_ready) begin
                    shift_d = shift_q >> PARTIAL_SUM_BW;
                    if (lane_q == LAST_LANE) begin
                        lane_d  = '0;
                        row_d   = row_q + ADDRESSSIZE'(1);
                        state_d = (CMP_W'(row_q) + CMP_W'(1) == CMP_W'(num_q)) ? DONE : READ;
                    end else begin
                        lane_d = lane_q + LANE_W'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output values are decoded from the next state so they land in flops.
    always_comb begin
        lane_val     = shift_d[PARTIAL_SUM_BW-1:0];
        busy_d       = (state_d == READ) || (state_d == WAIT) || (state_d == SEND);
        done_d       = (state_d == DONE);
        sram_rd_en_d = (state_d == READ);
        sram_addr_d  = (state_d == READ) ? (base_d + row_d) : sram_addr_q;
        m_valid_d    = (state_d == SEND);
        m_data_d     = (state_d == SEND) ? OUT_BW'($signed(lane_val)) : m_data_q;
        m_last_d     = (state_d == SEND) && (lane_d == LAST_LANE)
                       && (row_d == num_d - ADDRESSSIZE'(1));
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.sram_rd_en = sram_rd_en_q;
    assign bus.sram_addr  = sram_addr_q;
    assign bus.m_valid    = m_valid_q;
    assign bus.m_data     = m_data_q;
    assign bus.m_last     = m_last_q;
endmodule

// File: tb/tb_result_drain_ctrl.sv
// Self-checking bench for result_drain_ctrl: SRAM model, ready generator, stream monitor
// and a row/lane reference model that predicts every beat and read address.
module tb_result_drain_ctrl;
    localparam int unsigned AW = 10;
    localparam int unsigned PW = 20;
    localparam int unsigned MS = 8;
    localparam int unsigned OW = 32;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    result_drain_ctrl_if #(.ADDRESSSIZE(AW), .PARTIAL_SUM_BW(PW), .MATRIX_SIZE(MS), .OUT_BW(OW)) bus ();

    result_drain_ctrl #(.ADDRESSSIZE(AW), .PARTIAL_SUM_BW(PW), .MATRIX_SIZE(MS), .OUT_BW(OW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    logic [PW*MS-1:0] mem [1024];
    int n_pass = 0, n_fail = 0, n_total = 0;
    int ready_mode = 0;

    // monitor state
    int cyc = 0, start_cyc, first_valid, first_hs, last_hs, done_cnt, done_cyc, busy_cnt, stall_err;
    logic [OW:0]   beat_q[$];
    logic [AW-1:0] addr_q[$];
    logic          stall_pending = 1'b0;
    logic [OW-1:0] stall_data;
    logic          stall_last;

    always @(posedge clk) if (bus.sram_rd_en) bus.sram_rdata <= mem[bus.sram_addr];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [OW-1:0] sext_ref(input logic [PW-1:0] v);
        longint s;
        s = longint'(v);
        if (s >= (64'sd1 << (PW - 1))) s = s - (64'sd1 << PW);
        return OW'(s);
    endfunction

    task automatic clear_mon();
        beat_q.delete();
        addr_q.delete();
        start_cyc = -1; first_valid = -1; first_hs = -1; last_hs = -1;
        done_cnt = 0; done_cyc = -1; busy_cnt = 0; stall_err = 0;
    endtask

    // ready generator: 0 = always ready, 1 = pattern 1,0,0 repeating, 2 = random
    initial begin
        int ph = 0;
        bus.m_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                1:       begin bus.m_ready = (ph == 0); ph = (ph + 1) % 3; end
                2:       bus.m_ready = 1'($urandom_range(0, 1));
                default: bus.m_ready = 1'b1;
            endcase
        end
    end

    // stream / SRAM-port monitor, sampled mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (stall_pending && !(bus.m_valid && bus.m_data === stall_data && bus.m_last === stall_last))
                stall_err++;
            stall_pending = bus.m_valid && !bus.m_ready;
            stall_data    = bus.m_data;
            stall_last    = bus.m_last;
            if (bus.start && start_cyc < 0) start_cyc = cyc;
            if (bus.sram_rd_en) addr_q.push_back(bus.sram_addr);
            if (bus.m_valid && first_valid < 0) first_valid = cyc;
            if (bus.m_valid && bus.m_ready) begin
                beat_q.push_back({bus.m_last, bus.m_data});
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
            end
            if (bus.done) begin done_cnt++; done_cyc = cyc; end
            if (bus.busy) busy_cnt++;
        end
    end

    task automatic run_drain(input int base, input int n, input int mode, input int spur, input int spur_base);
        logic [PW*MS-1:0] row;
        logic [OW:0]      exp_beat, obs_beat;
        logic [AW-1:0]    obs_addr;
        int               idx, a;
        clear_mon();
        ready_mode = mode;
        @(posedge clk); #1;
        bus.base_addr = AW'(base);
        bus.num_rows  = AW'(n);
        bus.start     = 1'b1;
        for (int i = 0; i < 2000 && done_cnt == 0; i++) begin
            @(posedge clk); #1;
            bus.start = (i == spur);
            if (i == spur) begin
                bus.base_addr = AW'(spur_base);
                bus.num_rows  = AW'(n + 1);
            end
        end
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("done_seen", 64'(done_cnt > 0), 64'(1));
        chk("done_count", 64'(done_cnt), 64'(1));
        chk("beat_count", 64'(beat_q.size()), 64'(n * MS));
        chk("addr_count", 64'(addr_q.size()), 64'(n));
        chk("stall_stability", 64'(stall_err), 64'(0));
        for (int r = 0; r < n; r++) begin
            a = (base + r) % 1024;
            row = mem[a];
            obs_addr = (r < addr_q.size()) ? addr_q[r] : 'x;
            chk($sformatf("addr_r%0d", r), 64'(obs_addr), 64'(a));
            for (int l = 0; l < int'(MS); l++) begin
                idx = r * MS + l;
                exp_beat = {1'(r == n - 1 && l == MS - 1), sext_ref(row[l*PW +: PW])};
                obs_beat = (idx < beat_q.size()) ? beat_q[idx] : 'x;
                chk($sformatf("beat_r%0d_l%0d", r, l), 64'(obs_beat), 64'(exp_beat));
            end
        end
        if (n > 0 && mode == 0) begin
            chk("first_valid_latency", 64'(first_valid - start_cyc), 64'(3));
            chk("busy_cycles", 64'(busy_cnt), 64'(n * (2 + MS)));
            chk("done_after_last", 64'(done_cyc - last_hs), 64'(1));
            chk("beat_span", 64'(last_hs - first_hs), 64'(n * (2 + MS) - 3));
        end
        if (n == 0) begin
            chk("empty_done_latency", 64'(done_cyc - start_cyc), 64'(1));
            chk("empty_no_valid", 64'(first_valid), 64'(-1));
            chk("empty_no_busy", 64'(busy_cnt), 64'(0));
        end
    endtask

    initial begin
        int nb;
        rstn = 1'b0;
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.num_rows = '0;
        for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom, $urandom};
        for (int l = 0; l < int'(MS); l++) mem[0][l*PW +: PW] = PW'(l + 1);
        mem[5][0*PW +: PW] = 20'hFFFFF;
        mem[5][1*PW +: PW] = 20'h80000;
        mem[5][2*PW +: PW] = 20'h7FFFF;
        bus.sram_rdata = '0;
        clear_mon();

        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        chk("rst_rd_en", 64'(bus.sram_rd_en), 64'(0));
        chk("rst_valid", 64'(bus.m_valid), 64'(0));
        chk("rst_last", 64'(bus.m_last), 64'(0));
        chk("rst_addr", 64'(bus.sram_addr), 64'(0));
        chk("rst_data", 64'(bus.m_data), 64'(0));
        @(posedge clk); #1;
        rstn = 1'b1;

        run_drain(0, 1, 0, -1, 0);
        run_drain(5, 1, 0, -1, 0);
        chk("sext_neg1", 64'(beat_q[0][OW-1:0]), 64'(32'hFFFFFFFF));
        chk("sext_min", 64'(beat_q[1][OW-1:0]), 64'(32'hFFF80000));
        chk("sext_max", 64'(beat_q[2][OW-1:0]), 64'(32'h0007FFFF));
        run_drain(16, 2, 1, -1, 0);
        run_drain(10'h3FE, 3, 2, -1, 0);
        run_drain(7, 0, 0, -1, 0);
        run_drain(40, 4, 0, 10, 10'h050);

        // asynchronous reset while presenting row 1, lane 3
        clear_mon();
        ready_mode = 0;
        @(posedge clk); #1;
        bus.base_addr = 10'h100;
        bus.num_rows  = 10'd3;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 200 && beat_q.size() < MS + 3; i++) begin
            @(posedge clk); #1;
        end
        chk("pre_reset_beats", 64'(beat_q.size()), 64'(MS + 3));
        #2 rstn = 1'b0;
        #1;
        chk("arst_valid", 64'(bus.m_valid), 64'(0));
        chk("arst_busy", 64'(bus.busy), 64'(0));
        chk("arst_done", 64'(bus.done), 64'(0));
        chk("arst_last", 64'(bus.m_last), 64'(0));
        nb = beat_q.size();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("post_reset_no_beats", 64'(beat_q.size()), 64'(nb));
        chk("post_reset_idle", 64'({bus.busy, bus.m_valid, bus.done}), 64'(0));
        run_drain(10'h200, 2, 0, -1, 0);

        for (int k = 0; k < 3; k++)
            run_drain(int'($urandom_range(0, 1023)), int'($urandom_range(1, 5)), 2, -1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed %0d of %0d checks done", n_pass, n_total);
        $fatal(1, "watchdog");
    end
endmodule
